// File: rtl/alu8_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu8_reg                                                |
// | Brief    : 8-bit arithmetic/logic unit with registered result and  |
// |            carry, zero and signed-overflow flags (1-cycle latency) |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module alu8_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  input  logic [2:0] control_line,
  input  logic       mode_select,
  output logic [7:0] out,
  output logic       c_out,
  output logic       zero,
  output logic       ovf
);

  localparam logic [2:0] OP_ADC   = 3'd0;
  localparam logic [2:0] OP_SBB   = 3'd1;
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_DEC   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_SHL   = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_NEG   = 3'd7;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  // Nine-bit sum/difference: bit 8 is the carry (add) or borrow (subtract).
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] res;
  logic       cy;
  logic       ov;

  assign sum9  = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
  assign diff9 = {1'b0, a} - {1'b0, b} - {8'd0, c_in};

  // Combinational result and flag selection for the current inputs.
  always_comb begin
    res = 8'h00;
    cy  = 1'b0;
    ov  = 1'b0;
    if (!mode_select) begin
      case (control_line)
        OP_ADC: begin
          res = sum9[7:0];
          cy  = sum9[8];
          ov  = (a[7] == b[7]) && (sum9[7] != a[7]);
        end
        OP_SBB: begin
          res = diff9[7:0];
          cy  = diff9[8];
          ov  = (a[7] != b[7]) && (diff9[7] != a[7]);
        end
        OP_INC: begin
          res = a + 8'd1;
          cy  = (a == 8'hFF);
          ov  = (a == 8'h7F);
        end
        OP_DEC: begin
          res = a - 8'd1;
          cy  = (a == 8'h00);
          ov  = (a == 8'h80);
        end
        OP_PASSA: res = a;
        OP_SHL: begin
          res = {a[6:0], 1'b0};
          cy  = a[7];
        end
        OP_SHR: begin
          res = {1'b0, a[7:1]};
          cy  = a[0];
        end
        OP_NEG: begin
          res = 8'h00 - a;
          cy  = (a != 8'h00);
          ov  = (a == 8'h80);
        end
        default: res = 8'h00;
      endcase
    end else begin
      case (control_line)
        OP_AND:   res = a & b;
        OP_OR:    res = a | b;
        OP_XOR:   res = a ^ b;
        OP_NAND:  res = ~(a & b);
        OP_NOR:   res = ~(a | b);
        OP_XNOR:  res = ~(a ^ b);
        OP_NOTA:  res = ~a;
        OP_PASSB: res = b;
        default:  res = 8'h00;
      endcase
    end
  end

  // Output register; zero is derived from the new result so it stays aligned with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= 8'h00;
      c_out <= 1'b0;
      zero  <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      out   <= res;
      c_out <= cy;
      zero  <= (res == 8'h00);
      ovf   <= ov;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu8_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_alu8_reg                                             |
// | Brief    : self-checking bench for alu8_reg against an integer     |
// |            arithmetic reference model                              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_alu8_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       c_in = 1'b0;
  logic [2:0] control_line = 3'd0;
  logic       mode_select = 1'b0;
  logic [7:0] out;
  logic       c_out;
  logic       zero;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  alu8_reg dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .c_in         (c_in),
    .control_line (control_line),
    .mode_select  (mode_select),
    .out          (out),
    .c_out        (c_out),
    .zero         (zero),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model computed with plain integer arithmetic.
  task automatic model(input int ia, input int ib, input int ic, input int op, input int md,
                       output int eo, output int ec, output int ez, output int ev);
    int s;
    eo = 0; ec = 0; ev = 0;
    if (md == 0) begin
      case (op)
        0: begin s = ia + ib + ic; eo = s % 256; ec = (s > 255);
                 s = sgn(ia) + sgn(ib) + ic; ev = (s > 127 || s < -128); end
        1: begin s = ia - ib - ic; eo = (s + 512) % 256; ec = (ia < ib + ic);
                 s = sgn(ia) - sgn(ib) - ic; ev = (s > 127 || s < -128); end
        2: begin eo = (ia + 1) % 256; ec = (ia == 255); ev = (ia == 127); end
        3: begin eo = (ia + 255) % 256; ec = (ia == 0); ev = (ia == 128); end
        4: eo = ia;
        5: begin eo = (ia * 2) % 256; ec = (ia >= 128); end
        6: begin eo = ia / 2; ec = ia % 2; end
        default: begin eo = (256 - ia) % 256; ec = (ia != 0); ev = (ia == 128); end
      endcase
    end else begin
      case (op)
        0: eo = ia & ib;
        1: eo = ia | ib;
        2: eo = ia ^ ib;
        3: eo = 255 - (ia & ib);
        4: eo = 255 - (ia | ib);
        5: eo = 255 - (ia ^ ib);
        6: eo = 255 - ia;
        default: eo = ib;
      endcase
    end
    ez = (eo == 0);
  endtask

  // Apply inputs, clock one edge, check registered outputs #1 later.
  task automatic step(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic [2:0] op, input logic md, input logic r);
    int eo, ec, ez, ev;
    a = ia; b = ib; c_in = ic; control_line = op; mode_select = md; rst = r;
    if (r) begin eo = 0; ec = 0; ez = 1; ev = 0; end
    else model(int'(ia), int'(ib), int'(ic), int'(op), int'(md), eo, ec, ez, ev);
    @(posedge clk); #1;
    chk({tag, ".out"},  int'(out),   eo);
    chk({tag, ".cout"}, int'(c_out), ec);
    chk({tag, ".zero"}, int'(zero),  ez);
    chk({tag, ".ovf"},  int'(ovf),   ev);
  endtask

  initial begin
    #1;
    // Reset with all-ones operands, then release.
    step("rst0", 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b1);
    step("rst1", 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b1);
    step("post_rst", 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("post_rst.lit", int'(out), 'hFE);

    // Directed sweeps of both banks.
    for (int op = 0; op < 8; op++) step($sformatf("arith%0d", op), 8'h02, 8'h03, 1'b0, 3'(op), 1'b0, 1'b0);
    for (int op = 0; op < 8; op++) step($sformatf("logic%0d", op), 8'h02, 8'h03, 1'b1, 3'(op), 1'b1, 1'b0);

    // Boundary cases.
    step("adc7f01", 8'h7F, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("adc7f01.lit", int'(ovf), 1);
    step("adcff00c", 8'hFF, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    step("sbb8001", 8'h80, 8'h01, 1'b0, 3'd1, 1'b0, 1'b0);
    step("neg80", 8'h80, 8'h00, 1'b0, 3'd7, 1'b0, 1'b0);
    step("shl81", 8'h81, 8'h00, 1'b0, 3'd5, 1'b0, 1'b0);
    step("shr01", 8'h01, 8'h00, 1'b0, 3'd6, 1'b0, 1'b0);
    step("incff", 8'hFF, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0);
    step("inc7f", 8'h7F, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0);
    step("dec00", 8'h00, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0);
    step("dec80", 8'h80, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0);
    step("neg00", 8'h00, 8'h00, 1'b0, 3'd7, 1'b0, 1'b0);
    step("sbb00c", 8'h00, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0);

    // Mid-stream reset during back-to-back ADC.
    for (int i = 0; i < 6; i++)
      step($sformatf("mid%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 3'd0, 1'b0, (i == 3));

    // Randomized operation mix.
    for (int i = 0; i < 400; i++)
      step($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom),
           3'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
